// File: rtl/ll_req_arbiter.sv
// ll_req_arbiter
// Round-robin arbiter in front of the single linked-list engine request port.
// A winning request is captured into holding registers and presented to the
// engine with a level-held valid until the engine reports completion (or the
// watchdog expires). The owner then gets a one-cycle done pulse.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_vld_in             per-requester request valid (held until acked)
//   req_*_in               packed per-requester fields, slice i at [i*W +: W]
//   req_ack                one-hot, combinational: request captured this cycle
//   req_done / req_err     one-hot done pulse, err=1 when ended by timeout
//   eng_req_vld, eng_req_* request presented to the engine
//   intf_ready             engine can accept a new request
//   resp_gen_cmpltd        engine finished the current request (pulse)
//   busy, grant_id         grant outstanding, current/most recent winner
module ll_req_arbiter #(
  parameter int NUM_REQ            = 2,
  parameter int OP_WIDTH           = 4,
  parameter int HEADPTR_ADDR_WIDTH = 2,
  parameter int NODENUM_WIDTH      = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_vld_in,
  input  logic [NUM_REQ*OP_WIDTH-1:0]           req_main_op_in,
  input  logic [NUM_REQ*OP_WIDTH-1:0]           req_spec_in,
  input  logic [NUM_REQ*HEADPTR_ADDR_WIDTH-1:0] req_ll_num_in,
  input  logic [NUM_REQ*NODENUM_WIDTH-1:0]      req_pos_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_data_in,
  output logic [NUM_REQ-1:0]                    req_ack,
  output logic [NUM_REQ-1:0]                    req_done,
  output logic                                  req_err,
  output logic                                  eng_req_vld,
  output logic [OP_WIDTH-1:0]                   eng_req_main_op,
  output logic [OP_WIDTH-1:0]                   eng_req_spec,
  output logic [HEADPTR_ADDR_WIDTH-1:0]         eng_req_ll_num,
  output logic [NODENUM_WIDTH-1:0]              eng_req_pos,
  output logic [DATA_WIDTH-1:0]                 eng_req_data,
  input  logic                                  intf_ready,
  input  logic                                  resp_gen_cmpltd,
  output logic                                  busy,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [OP_WIDTH-1:0]           main_op_q, main_op_d;
  logic [OP_WIDTH-1:0]           spec_q, spec_d;
  logic [HEADPTR_ADDR_WIDTH-1:0] ll_num_q, ll_num_d;
  logic [NODENUM_WIDTH-1:0]      pos_q, pos_d;
  logic [DATA_WIDTH-1:0]         data_q, data_d;
  logic [GW-1:0]                 grant_id_q, grant_id_d;
  logic [GW-1:0]                 last_grant_q, last_grant_d;
  logic [WW-1:0]                 wdog_q, wdog_d;
  logic [NUM_REQ-1:0]            done_q, done_d;
  logic                          err_q, err_d;

  logic          found;
  logic [GW-1:0] winner;
  logic          take;

  // Round-robin search: offsets are walked from farthest to nearest so the
  // nearest valid requester after last_grant is the one left in winner.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (req_vld_in[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  // Ack is suppressed during reset because nothing would be captured.
  assign take = (state_q == IDLE) && intf_ready && found && !reset;

  always_comb begin
    req_ack = '0;
    if (take) req_ack[winner] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    main_op_d    = main_op_q;
    spec_d       = spec_q;
    ll_num_d     = ll_num_q;
    pos_d        = pos_q;
    data_d       = data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    done_d       = '0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          main_op_d    = req_main_op_in[winner*OP_WIDTH +: OP_WIDTH];
          spec_d       = req_spec_in[winner*OP_WIDTH +: OP_WIDTH];
          ll_num_d     = req_ll_num_in[winner*HEADPTR_ADDR_WIDTH +: HEADPTR_ADDR_WIDTH];
          pos_d        = req_pos_in[winner*NODENUM_WIDTH +: NODENUM_WIDTH];
          data_d       = req_data_in[winner*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d   = winner;
          last_grant_d = winner;
          wdog_d       = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        wdog_d = wdog_q + 1'b1;
        // Completion takes precedence over a coincident watchdog expiry.
        if (resp_gen_cmpltd) begin
          state_d            = IDLE;
          done_d[grant_id_q] = 1'b1;
        end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d            = IDLE;
          done_d[grant_id_q] = 1'b1;
          err_d              = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      main_op_q    <= '0;
      spec_q       <= '0;
      ll_num_q     <= '0;
      pos_q        <= '0;
      data_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      wdog_q       <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_op_q    <= main_op_d;
      spec_q       <= spec_d;
      ll_num_q     <= ll_num_d;
      pos_q        <= pos_d;
      data_q       <= data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy            = (state_q == BUSY);
  assign eng_req_vld     = (state_q == BUSY);
  assign eng_req_main_op = main_op_q;
  assign eng_req_spec    = spec_q;
  assign eng_req_ll_num  = ll_num_q;
  assign eng_req_pos     = pos_q;
  assign eng_req_data    = data_q;
  assign grant_id        = grant_id_q;
  assign req_done        = done_q;
  assign req_err         = err_q;

endmodule

// File: doc/ll_req_arbiter.md
# ll_req_arbiter

Round-robin arbiter that shares the single linked-list engine request port between NUM_REQ independent requesters, such as the ROM DMA instruction builder and a host command decoder. It captures the winning request into holding registers and presents it to the engine with a level-held valid. It holds that grant until the engine reports response completion, then returns a per-requester done pulse. A watchdog releases the grant if the engine never completes.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- OP_WIDTH, 4: width of the main-op and specifier codes.
- HEADPTR_ADDR_WIDTH, 2: list-number width.
- NODENUM_WIDTH, 4: node-position width.
- DATA_WIDTH, 8: payload width.
- TIMEOUT_CYCLES, 1024: engine completion watchdog limit (≥2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_vld_in  in  NUM_REQ  per-requester request valid; held until acked.
- req_main_op_in  in  NUM_REQ*OP_WIDTH  main-op code; slice i is [i*OP_WIDTH +: OP_WIDTH].
- req_spec_in  in  NUM_REQ*OP_WIDTH  specifier code, same slicing.
- req_ll_num_in  in  NUM_REQ*HEADPTR_ADDR_WIDTH  list number.
- req_pos_in  in  NUM_REQ*NODENUM_WIDTH  node position.
- req_data_in  in  NUM_REQ*DATA_WIDTH  payload.
- req_ack  out  NUM_REQ  one-hot pulse: the request has been captured.
- req_done  out  NUM_REQ  one-hot pulse: the engine has finished the granted request.
- req_err  out  1  qualifies req_done; 1 means the request ended by timeout.
- eng_req_vld  out  1  request valid to the engine.
- eng_req_main_op, eng_req_spec, eng_req_ll_num, eng_req_pos, eng_req_data  out  widths as above  captured request fields.
- intf_ready  in  1  the engine can accept a new request.
- resp_gen_cmpltd  in  1  the engine response is complete (1-cycle pulse).
- busy  out  1  a grant is outstanding.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant.

## Operation
- The FSM has two states: IDLE and BUSY.
- **IDLE**
  - When intf_ready=1 and req_vld_in≠0, select a winner by round robin. The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - In the same cycle:
    - assert req_ack[winner] combinationally;
    - capture the winner's field slices into holding registers;
    - load grant_id=winner and last_grant=winner;
    - clear the watchdog;
    - go to BUSY.
  - While intf_ready=0, the arbiter does not ack and stays in IDLE.
- **BUSY**
  - eng_req_vld=1; the eng_req_* outputs come from the holding registers and are stable for the whole state.
  - The watchdog increments every cycle.
  - If resp_gen_cmpltd=1, go to IDLE. In the next cycle (registered) req_done[grant_id]=1 and req_err=0.
  - Otherwise, if the watchdog equals TIMEOUT_CYCLES-1, go to IDLE. In the next cycle req_done[grant_id]=1 and req_err=1.
  - If resp_gen_cmpltd and the timeout condition occur in the same cycle, completion wins (req_err=0).
  - req_vld_in and intf_ready are ignored while BUSY; no ack is issued.
- A requester must hold its vld and fields stable until it sees its ack.
- A requester may deassert vld before it is acked; it then loses the request with no side effects.
- A requester may raise a new request before its done pulse arrives. That request is arbitrated normally once the FSM is back in IDLE.
- Requester indices at or above NUM_REQ do not exist; grant_id never takes such a value.

## Timing
- Reset values:
  - state IDLE, busy=0, eng_req_vld=0;
  - all eng_req_* fields 0;
  - req_ack=0, req_done=0, req_err=0;
  - grant_id=0, last_grant=NUM_REQ-1, so requester 0 has first priority;
  - watchdog 0.
- Reset asserted mid-BUSY: the next cycle is IDLE with all outputs at reset values. No done pulse is issued for the aborted request.
- Ack latency is 0 cycles: the ack appears in the cycle where IDLE, intf_ready and req_vld_in coincide.
- eng_req_vld rises in the cycle after the ack.
- req_done rises 1 cycle after resp_gen_cmpltd and lasts exactly 1 cycle.
- IDLE is re-entered in that same cycle, so a new ack can coincide with the previous request's done pulse. The minimum grant-to-grant spacing is 2 cycles per request plus the engine latency.
- busy = (state==BUSY).
- On timeout, eng_req_vld is high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Single requester: reset; req_vld_in=01 with op=3, spec=1, ll=2, pos=5, data=0xA5; intf_ready=1. Expect ack[0] in cycle 0, and from cycle 1 eng_req_vld=1 with the same fields. Pulse resp_gen_cmpltd at cycle 4: expect done[0]=1 and err=0 at cycle 5, and busy=0 at cycle 5.
- Fairness: NUM_REQ=2, req_vld_in held at 11, engine completes 2 cycles after each eng_req_vld. Expect grants 0,1,0,1 and acks alternating.
- Backpressure: req_vld_in=10 with intf_ready=0 for 6 cycles. Expect no ack and eng_req_vld=0. When intf_ready rises, expect ack[1] that same cycle.
- Timeout: TIMEOUT_CYCLES=8, with resp_gen_cmpltd never asserted. Expect eng_req_vld high for 8 cycles, then done[g]=1 with err=1, then IDLE.
- Completion on the timeout boundary: resp_gen_cmpltd in the watchdog=7 cycle (TIMEOUT_CYCLES=8). Expect a done pulse with err=0.
- Reset mid-BUSY: assert reset at cycle 3 of BUSY. Expect every output at its reset value the next cycle and no done pulse; after release, requester 0 wins first.
